uart_buffered: RTL

UART_BUFFERED -- requirements
Module: uart_buffered

---
 rtl/uart_buffered_if.sv | 36 +++
 rtl/uart_buffered.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_if.sv
// ---------------------------------------------------------------------------
// uart_buffered_if -- bus bundle for uart_buffered.
//
// Groups the buffered-UART host and serial signals into one bundle.
//   master : host/line side. Drives tx_data_in, tx_write_en, rx_in and
//            rx_read_en.
//   slave  : the UART itself. Drives tx_full, tx_busy, tx_out, rx_data_out,
//            rx_empty, rx_overrun, framing_err and parity_err.
// WORD_SIZE must match the WORD_SIZE of the uart_buffered it connects to.
// ---------------------------------------------------------------------------
interface uart_buffered_if #(parameter int WORD_SIZE = 8);
    logic [WORD_SIZE-1:0] tx_data_in;
    logic                 tx_write_en;
    logic                 tx_full;
    logic                 tx_busy;
    logic                 tx_out;
    logic                 rx_in;
    logic                 rx_read_en;
    logic [WORD_SIZE-1:0] rx_data_out;
    logic                 rx_empty;
    logic                 rx_overrun;
    logic                 framing_err;
    logic                 parity_err;

    modport master (
        output tx_data_in, tx_write_en, rx_in, rx_read_en,
        input  tx_full, tx_busy, tx_out, rx_data_out, rx_empty,
               rx_overrun, framing_err, parity_err
    );

    modport slave (
        input  tx_data_in, tx_write_en, rx_in, rx_read_en,
        output tx_full, tx_busy, tx_out, rx_data_out, rx_empty,
               rx_overrun, framing_err, parity_err
    );
endinterface

// File: rtl/uart_buffered.sv
// ---------------------------------------------------------------------------
// uart_buffered -- UART with a TX FIFO and an RX FIFO.
//
// Frame format: 1 start bit (0), WORD_SIZE data bits sent LSB first, an
// optional even-parity bit, and 1 stop bit (1). Each bit lasts CLKS_PER_BIT
// clk cycles.
//
// Build option: defining UART_PARITY_EN adds the parity bit on transmit and
// checks it on receive. Without it, parity_err is tied to 0.
//
// Ports:
//   clk, reset_b      system clock (rising edge); asynchronous active-low reset
//   bus (slave):
//     tx_data_in/tx_write_en   word to push into the TX FIFO; a push while
//                              the FIFO is full is ignored
//     tx_full, tx_busy         TX FIFO full; frame in flight or FIFO non-empty
//     tx_out                   serial line out, idle high
//     rx_in                    asynchronous serial line in
//     rx_read_en               pop the RX FIFO head; ignored while empty
//     rx_data_out, rx_empty    first-word-fall-through head; all ones when empty
//     rx_overrun               sticky until the next rx_read_en
//     framing_err, parity_err  one-cycle pulses
// ---------------------------------------------------------------------------
module uart_buffered #(
    parameter int WORD_SIZE       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CLKS_PER_BIT    = 16
) (
    input  logic           clk,
    input  logic           reset_b,
    uart_buffered_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- TX FIFO + FSM ----------------
    logic [WORD_SIZE-1:0] tx_mem [DEPTH];
    logic [PW-1:0]        tx_wptr, tx_rptr;
    logic                 tx_empty, tx_full, tx_wr, tx_pop, tx_bit_end;
    state_t               tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [WORD_SIZE-1:0] tx_shift;
    logic                 tx_par, tx_line, tx_busy_q;

    assign tx_empty   = (tx_wptr == tx_rptr);
    assign tx_full    = (tx_wptr[PW-1] != tx_rptr[PW-1]) &&
                        (tx_wptr[PW-2:0] == tx_rptr[PW-2:0]);
    assign tx_wr      = bus.tx_write_en && !tx_full;
    assign tx_bit_end = (tx_cnt == CNT_LAST);
    // Pop on IDLE exit and at the end of a stop bit (back-to-back frames).
    assign tx_pop     = !tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_bit_end));

    always_ff @(posedge clk)
        if (tx_wr) tx_mem[tx_wptr[PW-2:0]] <= bus.tx_data_in;

    // tx_line lags tx_state by one cycle: a push at edge N leaves IDLE at
    // N+1, and the line falls at N+2.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_line   <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            if (tx_wr) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop) begin
                tx_rptr  <= tx_rptr + 1'b1;
                tx_shift <= tx_mem[tx_rptr[PW-2:0]];
                tx_par   <= ^tx_mem[tx_rptr[PW-2:0]];
            end
            // Stays high through the last cycle of the stop bit.
            tx_busy_q <= (tx_state != IDLE) || !tx_empty;
            tx_cnt    <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                IDLE: begin
                    tx_line <= 1'b1;
                    tx_cnt  <= '0;
                    if (!tx_empty) tx_state <= START;
                end
                START: begin
                    tx_line <= 1'b0;
                    if (tx_bit_end) begin
                        tx_state <= DATA;
                        tx_bit   <= '0;
                    end
                end
                DATA: begin
                    tx_line <= tx_shift[0];
                    if (tx_bit_end) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == BIT_LAST)
`ifdef UART_PARITY_EN
                            tx_state <= PARITY;
`else
                            tx_state <= STOP;
`endif
                    end
                end
                PARITY: begin
                    tx_line <= tx_par;
                    if (tx_bit_end) tx_state <= STOP;
                end
                STOP: begin
                    tx_line <= 1'b1;
                    if (tx_bit_end) tx_state <= tx_empty ? IDLE : START;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO + FSM ----------------
    logic [WORD_SIZE-1:0] rx_mem [DEPTH];
    logic [PW-1:0]        rx_wptr, rx_rptr;
    logic                 rx_empty, rx_full, rx_rd, rx_wr, rx_stop_smp;
    logic                 rx_meta, rx_sync, rx_prev;
    state_t               rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [WORD_SIZE-1:0] rx_shift;
    logic                 rx_par_bad, rx_overrun_q, framing_err_q;
`ifdef UART_PARITY_EN
    logic                 parity_err_q;
`endif

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[PW-1] != rx_rptr[PW-1]) &&
                         (rx_wptr[PW-2:0] == rx_rptr[PW-2:0]);
    assign rx_rd       = bus.rx_read_en && !rx_empty;
    assign rx_stop_smp = (rx_state == STOP) && (rx_cnt == CNT_LAST);
    // A concurrent read frees a slot, so a write into a full FIFO still lands.
    assign rx_wr       = rx_stop_smp && rx_sync && !rx_par_bad && (!rx_full || rx_rd);

    always_ff @(posedge clk)
        if (rx_wr) rx_mem[rx_wptr[PW-2:0]] <= rx_shift;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            rx_wptr       <= '0;
            rx_rptr       <= '0;
            rx_state      <= IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bad    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta       <= bus.rx_in;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            framing_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_rd) begin
                rx_rptr      <= rx_rptr + 1'b1;
                rx_overrun_q <= 1'b0;
            end
            if (rx_wr) rx_wptr <= rx_wptr + 1'b1;
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= START;
                end
                // Half a bit in: still low means a real start bit, and from
                // here every later sample lands one full bit on, at centre.
                START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt     <= '0;
                        rx_bit     <= '0;
                        rx_par_bad <= 1'b0;
                        rx_state   <= rx_sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[WORD_SIZE-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == BIT_LAST)
`ifdef UART_PARITY_EN
                            rx_state <= PARITY;
`else
                            rx_state <= STOP;
`endif
                    end
                end
                PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= STOP;
                        if (rx_sync != ^rx_shift) begin
                            rx_par_bad <= 1'b1;
`ifdef UART_PARITY_EN
                            parity_err_q <= 1'b1;
`endif
                        end
                    end
                end
                STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_state <= IDLE;
                        if (!rx_sync)
                            framing_err_q <= 1'b1;
                        else if (!rx_par_bad && rx_full && !rx_rd)
                            rx_overrun_q <= 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_full     = tx_full;
    assign bus.tx_busy     = tx_busy_q || !tx_empty;
    assign bus.tx_out      = tx_line;
    assign bus.rx_empty    = rx_empty;
    assign bus.rx_data_out = rx_empty ? '1 : rx_mem[rx_rptr[PW-2:0]];
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.framing_err = framing_err_q;
`ifdef UART_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`else
    assign bus.parity_err  = 1'b0;
`endif
endmodule
